shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier: N-bit multiplicand times N-bit multiplier.
- Companion to the restoring shift-subtract divider and shares its start/busy/valid handshake, so a test harness can chain multiply→divide and check round trips.
- One accumulator addition and one right shift of {A,Q} per multiplier bit, sequenced by an internal FSM and iteration counter.
- Returns the low N bits of the product; flags overflow when the high half is nonzero.

---
 rtl/shift_add_multiplier_if.sv | 23 ++
 rtl/shift_add_multiplier.sv | 109 ++++++++++
 tb/tb_shift_add_multiplier.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/valid handshake bundle shared by the shift-add multiplier and its
// companion divider; master drives the request, slave returns status and result.
interface shift_add_multiplier_if #(
  parameter int unsigned N = 10
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         valid;
  logic         ovf;
  logic [N-1:0] p_out;

  modport master (
    output start, a_in, b_in,
    input  busy, valid, ovf, p_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, valid, ovf, p_out
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, low N bits of a*b with overflow flag.
// Optional macro MULT_ZERO_BYPASS_EN adds a ZeroCheck state that short-cuts zero operands.
module shift_add_multiplier #(
  parameter int unsigned N = 10
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   sclr,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StTest,
    StAdd,
    StShift,
    StDone,
    StOvf,
    StValid
`ifdef MULT_ZERO_BYPASS_EN
    , StZeroCheck
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    m_q;
  logic [N-1:0]    q_q;
  logic [N:0]      a_q;
  logic [CntW-1:0] cnt_q;
  logic            last_iter;
  logic [N:0]      add_sum;

  assign last_iter = (cnt_q == CntW'(N - 1));
  // Carry of the N-bit add lands in a_q[N] and is shifted down into the product.
  assign add_sum   = {1'b0, a_q[N-1:0]} + {1'b0, m_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
`ifdef MULT_ZERO_BYPASS_EN
      StLoad:  state_d = StZeroCheck;
      StZeroCheck: begin
        if (m_q == '0 || q_q == '0) state_d = StValid;
        else                        state_d = StTest;
      end
`else
      StLoad:  state_d = StTest;
`endif
      StTest:  state_d = q_q[0] ? StAdd : StShift;
      StAdd:   state_d = StShift;
      StShift: state_d = last_iter ? StDone : StTest;
      StDone:  state_d = (a_q[N-1:0] != '0) ? StOvf : StValid;
      StOvf:   state_d = StIdle;
      StValid: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (sclr) state_d = StIdle;
  end

  // Datapath freezes on sclr so a cleared run leaves its partial Q visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      q_q   <= '0;
      a_q   <= '0;
      cnt_q <= '0;
    end else if (!sclr) begin
      case (state_q)
        StLoad: begin
          m_q   <= bus.a_in;
          q_q   <= bus.b_in;
          a_q   <= '0;
          cnt_q <= '0;
        end
`ifdef MULT_ZERO_BYPASS_EN
        StZeroCheck: begin
          if (m_q == '0 || q_q == '0) q_q <= '0;
        end
`endif
        StAdd: a_q <= add_sum;
        StShift: begin
          {a_q, q_q} <= {1'b0, a_q, q_q[N-1:1]};
          cnt_q      <= cnt_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy  = (state_q != StIdle);
    bus.valid = (state_q == StValid);
    bus.ovf   = (state_q == StOvf);
    bus.p_out = q_q;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (N=10); expected cycle counts
// follow 2N+popcount(b)+3, plus one when MULT_ZERO_BYPASS_EN is defined.
module tb_shift_add_multiplier;

  localparam int unsigned N = 10;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int Zb = 1;
`else
  localparam int Zb = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sclr;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .sclr (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one operation; report the result cycle (cycle 1 = Load), flags and p_out.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int cyc,
                        output logic v, output logic o, output logic [N-1:0] p,
                        output logic busy_ok, output logic busy_after);
    int c;
    cyc = -1; v = 1'b0; o = 1'b0; p = '0; busy_ok = 1'b1;
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (cyc < 0 && c <= 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.valid || bus.ovf) begin
        cyc = c; v = bus.valid; o = bus.ovf; p = bus.p_out;
      end else begin
        if (c == 2) begin
          bus.a_in = ~a;
          bus.b_in = a ^ b ^ 10'h2a5;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    @(posedge clk); #1;
    busy_after = bus.busy;
  endtask

  int            cyc;
  logic          v, o, bok, baft;
  logic [N-1:0]  p;

  initial begin
    int n_res, last, c;
    logic prev_valid, seen;

    rst = 1'b1; sclr = 1'b0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy",  bus.busy,  0);
    check_eq("reset_valid", bus.valid, 0);
    check_eq("reset_ovf",   bus.ovf,   0);
    check_eq("reset_p",     bus.p_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(10'd3, 10'd5, cyc, v, o, p, bok, baft);
    check_eq("3x5_cycle", cyc, 25 + Zb);
    check_eq("3x5_valid", v, 1);
    check_eq("3x5_ovf",   o, 0);
    check_eq("3x5_p",     p, 15);
    check_eq("3x5_busy",  bok, 1);
    check_eq("3x5_idle",  baft, 0);

    run_op(10'd1023, 10'd1023, cyc, v, o, p, bok, baft);
    check_eq("ones_cycle", cyc, 33 + Zb);
    check_eq("ones_ovf",   o, 1);
    check_eq("ones_valid", v, 0);
    check_eq("ones_p",     p, 1);

    run_op(10'd32, 10'd32, cyc, v, o, p, bok, baft);
    check_eq("32x32_cycle", cyc, 24 + Zb);
    check_eq("32x32_ovf",   o, 1);
    check_eq("32x32_p",     p, 0);

    run_op(10'd0, 10'd777, cyc, v, o, p, bok, baft);
`ifdef MULT_ZERO_BYPASS_EN
    check_eq("zero_cycle", cyc, 3);
`else
    check_eq("zero_cycle", cyc, 27);
`endif
    check_eq("zero_valid", v, 1);
    check_eq("zero_p",     p, 0);

    run_op(10'd7, 10'd9, cyc, v, o, p, bok, baft);
    check_eq("7x9_cycle", cyc, 25 + Zb);
    check_eq("7x9_valid", v, 1);
    check_eq("7x9_p",     p, 63);

    // sclr in cycle 8 of 100*9
    @(negedge clk);
    bus.a_in = 10'd100; bus.b_in = 10'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    check_eq("sclr_busy", bus.busy, 0);
    check_eq("sclr_p",    bus.p_out, 2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid || bus.ovf || bus.busy) seen = 1'b1;
    end
    check_eq("sclr_quiet", seen, 0);
    run_op(10'd100, 10'd9, cyc, v, o, p, bok, baft);
    check_eq("100x9_cycle", cyc, 25 + Zb);
    check_eq("100x9_p",     p, 900);

    // asynchronous rst during Add, start held high throughout
    @(negedge clk);
    bus.a_in = 10'd3; bus.b_in = 10'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (2 + Zb) @(posedge clk);
    #1;
    check_eq("pre_rst_p", bus.p_out, 5);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy",  bus.busy,  0);
    check_eq("rst_valid", bus.valid, 0);
    check_eq("rst_ovf",   bus.ovf,   0);
    check_eq("rst_p",     bus.p_out, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_release_load", bus.busy, 1);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.ovf) begin
        seen = 1'b1;
        check_eq("post_rst_p", bus.p_out, 15);
      end
    end
    check_eq("post_rst_done", seen, 1);
    repeat (2) @(posedge clk);

    // start held continuously: one Idle cycle between results
    @(negedge clk);
    bus.a_in = 10'd2; bus.b_in = 10'd3; bus.start = 1'b1;
    n_res = 0; last = -1; prev_valid = 1'b0; c = 0;
    while (n_res < 3 && c < 300) begin
      @(posedge clk); #1;
      c++;
      if (prev_valid) check_eq("b2b_idle", bus.busy, 0);
      prev_valid = bus.valid;
      if (bus.valid) begin
        check_eq("b2b_p", bus.p_out, 6);
        if (last >= 0) check_eq("b2b_period", c - last, 26 + Zb);
        last = c;
        n_res++;
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_count", n_res, 3);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
